// File: rtl/jx2_alu_pkg.sv
// Purpose: shared encodings and lane helpers for the packed add/subtract datapath.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
//
// Contents:
//   SEG_WIDTH      carry-select segment width (byte granularity)
//   lane_e         lane-size encodings LANE_B/W/L/Q (8/16/32/64 bits)
//   sat_e          saturation encodings SAT_NONE/SAT_S/SAT_U (SAT_RSVD folds to wrap)
//   lane_first_seg true when a segment is the lowest segment of its lane
//   lane_last_seg  index of the highest segment in the lane holding a segment
package jx2_alu_pkg;

  localparam int SEG_WIDTH = 8;

  typedef enum logic [1:0] {
    LANE_B = 2'b00,
    LANE_W = 2'b01,
    LANE_L = 2'b10,
    LANE_Q = 2'b11
  } lane_e;

  typedef enum logic [1:0] {
    SAT_NONE = 2'b00,
    SAT_S    = 2'b01,
    SAT_U    = 2'b10,
    SAT_RSVD = 2'b11
  } sat_e;

  // A lane of size code L spans 2^L byte segments, so a segment starts a
  // lane exactly when its low L index bits are zero.
  function automatic logic lane_first_seg(input logic [1:0] lane, input int unsigned seg);
    int unsigned segs_per_lane;
    segs_per_lane = 32'd1 << lane;
    return (seg & (segs_per_lane - 32'd1)) == 32'd0;
  endfunction

  function automatic int unsigned lane_last_seg(input logic [1:0] lane, input int unsigned seg);
    int unsigned segs_per_lane;
    segs_per_lane = 32'd1 << lane;
    return seg | (segs_per_lane - 32'd1);
  endfunction

endpackage

// File: rtl/jx2_alu_seg8.sv
// Purpose: one carry-select byte segment; both candidate sums of a + (sub ? ~b : b).
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
//
// Ports:
//   i_a, i_b   operand bytes (Rm segment, Ri segment)
//   i_sub      invert i_b for subtraction
//   o_sum0     9-bit sum assuming carry-in 0 (bit 8 is the segment carry-out)
//   o_sum1     9-bit sum assuming carry-in 1
//   o_b_sign   sign bit of the (possibly inverted) second operand
module jx2_alu_seg8
  import jx2_alu_pkg::*;
(
  input  logic [SEG_WIDTH-1:0] i_a,
  input  logic [SEG_WIDTH-1:0] i_b,
  input  logic                 i_sub,
  output logic [SEG_WIDTH:0]   o_sum0,
  output logic [SEG_WIDTH:0]   o_sum1,
  output logic                 o_b_sign
);

  logic [SEG_WIDTH-1:0] w_b;

  assign w_b      = i_sub ? ~i_b : i_b;
  assign o_sum0   = {1'b0, i_a} + {1'b0, w_b};
  assign o_sum1   = {1'b0, i_a} + {1'b0, w_b} + {{SEG_WIDTH{1'b0}}, 1'b1};
  assign o_b_sign = w_b[SEG_WIDTH-1];

endmodule

// File: rtl/jx2_ex_padd_pipe.sv
// Purpose: EX-stage packed add/sub (8/16/32/64-bit lanes) with wrap, signed-sat, unsigned-sat and ADC/SBB carry.
// Latency: 2 register stages; operands presented before edge N are on the outputs after edge N+1 (sampled at N+2).
// Backpressure: inHold freezes both stages and the outputs; inValid during hold is dropped, issuer must re-present.
//
// Ports:
//   clock, reset          core clock, synchronous active-high reset (wins over inHold)
//   inValid, inHold       op valid this cycle / pipeline stall
//   inSub, inLane, inSat  add/sub, lane size code, saturation mode (11 behaves as wrap)
//   inCarry               carry-in (add) / not-borrow-in (sub), only for 64-bit lanes in wrap mode
//   regValRm, regValRi    operands
//   outValid, outResult   result valid / packed result
//   outCarry              carry-out of the lowest 64-bit lane (64-bit wrap only)
//   outLaneOvf            per-byte flag: lane saturated (sat modes) or signed-overflowed (wrap)
module jx2_ex_padd_pipe #(
  parameter int DATA_WIDTH = 64,
  parameter int SEG_WIDTH  = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      inValid,
  input  logic                      inHold,
  input  logic                      inSub,
  input  logic [1:0]                inLane,
  input  logic [1:0]                inSat,
  input  logic                      inCarry,
  input  logic [DATA_WIDTH-1:0]     regValRm,
  input  logic [DATA_WIDTH-1:0]     regValRi,
  output logic                      outValid,
  output logic [DATA_WIDTH-1:0]     outResult,
  output logic                      outCarry,
  output logic [DATA_WIDTH/8-1:0]   outLaneOvf
);

  import jx2_alu_pkg::*;

  localparam int NSEG   = DATA_WIDTH / SEG_WIDTH;
  localparam int SIDX_W = $clog2(NSEG);
  // Highest segment of the lowest 64-bit lane; its carry-out feeds outCarry.
  localparam int Q_LAST = (64 / SEG_WIDTH) - 1;

  // ---------------------------------------------------------------------------
  // Stage 1: per-segment candidate sums
  // ---------------------------------------------------------------------------
  logic [NSEG-1:0][SEG_WIDTH:0] w_sum0;
  logic [NSEG-1:0][SEG_WIDTH:0] w_sum1;
  logic [NSEG-1:0]              w_a_sign;
  logic [NSEG-1:0]              w_b_sign;

  for (genvar g = 0; g < NSEG; g++) begin : g_seg
    jx2_alu_seg8 u_seg (
      .i_a      (regValRm[g*SEG_WIDTH +: SEG_WIDTH]),
      .i_b      (regValRi[g*SEG_WIDTH +: SEG_WIDTH]),
      .i_sub    (inSub),
      .o_sum0   (w_sum0[g]),
      .o_sum1   (w_sum1[g]),
      .o_b_sign (w_b_sign[g])
    );
    assign w_a_sign[g] = regValRm[g*SEG_WIDTH + SEG_WIDTH - 1];
  end

  logic                         r_s1_vld;
  logic                         r_s1_sub;
  logic [1:0]                   r_s1_lane;
  logic [1:0]                   r_s1_sat;
  logic                         r_s1_cin;
  logic [NSEG-1:0][SEG_WIDTH:0] r_s1_sum0;
  logic [NSEG-1:0][SEG_WIDTH:0] r_s1_sum1;
  logic [NSEG-1:0]              r_s1_a_sign;
  logic [NSEG-1:0]              r_s1_b_sign;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_s1_vld    <= 1'b0;
      r_s1_sub    <= 1'b0;
      r_s1_lane   <= 2'b00;
      r_s1_sat    <= 2'b00;
      r_s1_cin    <= 1'b0;
      r_s1_sum0   <= '0;
      r_s1_sum1   <= '0;
      r_s1_a_sign <= '0;
      r_s1_b_sign <= '0;
    end else if (!inHold) begin
      r_s1_vld    <= inValid;
      r_s1_sub    <= inSub;
      r_s1_lane   <= inLane;
      // Reserved mode is folded to wrap here so stage 2 sees only three modes.
      r_s1_sat    <= (inSat == SAT_RSVD) ? SAT_NONE : inSat;
      r_s1_cin    <= inCarry;
      r_s1_sum0   <= w_sum0;
      r_s1_sum1   <= w_sum1;
      r_s1_a_sign <= w_a_sign;
      r_s1_b_sign <= w_b_sign;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: carry resolution, then per-lane overflow and saturation
  // ---------------------------------------------------------------------------
  logic                          w_lane_cin;
  logic [NSEG-1:0][SEG_WIDTH-1:0] w_raw;
  logic [NSEG-1:0]               w_cout;

  // Only 64-bit wrap lanes take the external carry; every other lane starts
  // with the +1 that completes two's-complement subtraction (or 0 for add).
  assign w_lane_cin = (r_s1_lane == LANE_Q && r_s1_sat == SAT_NONE) ? r_s1_cin : r_s1_sub;

  always_comb begin
    logic c;
    c      = 1'b0;
    w_raw  = '0;
    w_cout = '0;
    for (int s = 0; s < NSEG; s++) begin
      // The chain is cut at each lane boundary by reloading the lane carry.
      if (lane_first_seg(r_s1_lane, s)) c = w_lane_cin;
      w_raw[s]  = c ? r_s1_sum1[s][SEG_WIDTH-1:0] : r_s1_sum0[s][SEG_WIDTH-1:0];
      c         = c ? r_s1_sum1[s][SEG_WIDTH] : r_s1_sum0[s][SEG_WIDTH];
      w_cout[s] = c;
    end
  end

  logic [NSEG-1:0][SEG_WIDTH-1:0] w_res;
  logic [NSEG-1:0]                w_flag;

  always_comb begin
    logic [SIDX_W-1:0] last;
    logic a_s, b_s, r_s, sovf, lc, hi;
    last   = '0;
    a_s    = 1'b0;
    b_s    = 1'b0;
    r_s    = 1'b0;
    sovf   = 1'b0;
    lc     = 1'b0;
    hi     = 1'b0;
    w_res  = '0;
    w_flag = '0;
    for (int s = 0; s < NSEG; s++) begin
      // Every byte looks at the top segment of its own lane for the lane's
      // sign and carry, so the whole lane saturates and flags together.
      last = SIDX_W'(lane_last_seg(r_s1_lane, s));
      a_s  = r_s1_a_sign[last];
      b_s  = r_s1_b_sign[last];
      r_s  = w_raw[last][SEG_WIDTH-1];
      sovf = (a_s == b_s) && (r_s != a_s);
      lc   = w_cout[last];
      hi   = (last == SIDX_W'(s));

      w_res[s]  = w_raw[s];
      w_flag[s] = 1'b0;
      case (r_s1_sat)
        SAT_S: begin
          if (sovf) begin
            // Negative operands overflow towards 0x80..00, positive towards 0x7F..FF.
            if (a_s) w_res[s] = hi ? 8'h80 : 8'h00;
            else     w_res[s] = hi ? 8'h7F : 8'hFF;
            w_flag[s] = 1'b1;
          end
        end
        SAT_U: begin
          if (!r_s1_sub && lc) begin
            w_res[s]  = 8'hFF;
            w_flag[s] = 1'b1;
          end else if (r_s1_sub && !lc) begin
            w_res[s]  = 8'h00;
            w_flag[s] = 1'b1;
          end
        end
        default: w_flag[s] = sovf;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      outValid   <= 1'b0;
      outResult  <= '0;
      outCarry   <= 1'b0;
      outLaneOvf <= '0;
    end else if (!inHold) begin
      outValid   <= r_s1_vld;
      outResult  <= w_res;
      outCarry   <= (r_s1_lane == LANE_Q && r_s1_sat == SAT_NONE) ? w_cout[Q_LAST] : 1'b0;
      outLaneOvf <= r_s1_vld ? w_flag : '0;
    end
  end

endmodule

// File: tb/tb_jx2_ex_padd_pipe.sv
module tb_jx2_ex_padd_pipe;

  localparam int DW = 64;
  localparam int NB = DW / 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          inValid, inHold, inSub, inCarry;
  logic [1:0]    inLane, inSat;
  logic [DW-1:0] regValRm, regValRi;
  logic          outValid, outCarry;
  logic [DW-1:0] outResult;
  logic [NB-1:0] outLaneOvf;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [DW-1:0] res;
    logic          carry;
    logic [NB-1:0] ovf;
  } exp_t;

  typedef struct {
    exp_t e;
    int   age;
  } ent_t;

  jx2_ex_padd_pipe #(.DATA_WIDTH(DW), .SEG_WIDTH(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .inValid    (inValid),
    .inHold     (inHold),
    .inSub      (inSub),
    .inLane     (inLane),
    .inSat      (inSat),
    .inCarry    (inCarry),
    .regValRm   (regValRm),
    .regValRi   (regValRi),
    .outValid   (outValid),
    .outResult  (outResult),
    .outCarry   (outCarry),
    .outLaneOvf (outLaneOvf)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // Reference: each lane is taken as plain integers, summed with ordinary
  // arithmetic, then classified against the unsigned and signed ranges.
  function automatic exp_t model(input logic [DW-1:0] rm, input logic [DW-1:0] ri,
                                 input logic sub, input logic [1:0] lane,
                                 input logic [1:0] sat, input logic cin);
    exp_t e;
    int n;
    logic signed [67:0] ua, ub, sa, sb, ur, sr, two_n, smax, smin, ex, lres;
    logic wrap, uc, sovf, flag;
    e     = '0;
    n     = 8 << lane;
    two_n = 68'sd1 <<< n;
    smax  = (two_n >>> 1) - 68'sd1;
    smin  = -(two_n >>> 1);
    wrap  = (sat == 2'b00) || (sat == 2'b11);
    ex    = 68'sd0;
    if (wrap && lane == 2'b11) ex = sub ? {67'd0, ~cin} : {67'd0, cin};
    for (int l = 0; l < DW / n; l++) begin
      ua = '0;
      ub = '0;
      for (int b = 0; b < n; b++) begin
        ua[b] = rm[l*n + b];
        ub[b] = ri[l*n + b];
      end
      sa = ua[n-1] ? ua - two_n : ua;
      sb = ub[n-1] ? ub - two_n : ub;
      if (sub) begin
        ur = ua - ub - ex;
        sr = sa - sb - ex;
        uc = (ur >= 68'sd0);
      end else begin
        ur = ua + ub + ex;
        sr = sa + sb + ex;
        uc = (ur >= two_n);
      end
      sovf = (sr > smax) || (sr < smin);
      lres = ur;
      flag = 1'b0;
      if (sat == 2'b01) begin
        if (sovf) begin
          flag = 1'b1;
          lres = (sr > 68'sd0) ? smax : smin;
        end
      end else if (sat == 2'b10) begin
        if (!sub && uc) begin
          flag = 1'b1;
          lres = two_n - 68'sd1;
        end else if (sub && !uc) begin
          flag = 1'b1;
          lres = 68'sd0;
        end
      end else begin
        flag = sovf;
      end
      for (int b = 0; b < n; b++) e.res[l*n + b] = lres[b];
      for (int k = 0; k < n / 8; k++) e.ovf[l*(n/8) + k] = flag;
      if (l == 0 && wrap && lane == 2'b11) e.carry = uc;
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_op(input logic v, input logic sub, input logic [1:0] lane,
                        input logic [1:0] sat, input logic cin,
                        input logic [DW-1:0] rm, input logic [DW-1:0] ri);
    inValid  = v;
    inSub    = sub;
    inLane   = lane;
    inSat    = sat;
    inCarry  = cin;
    regValRm = rm;
    regValRi = ri;
  endtask

  // Byte-wise operands biased towards the sign/carry corners.
  function automatic logic [DW-1:0] rnd_operand();
    logic [DW-1:0] v;
    v = '0;
    for (int i = 0; i < NB; i++) begin
      case ($urandom_range(0, 5))
        0:       v[i*8 +: 8] = 8'h00;
        1:       v[i*8 +: 8] = 8'h7F;
        2:       v[i*8 +: 8] = 8'h80;
        3:       v[i*8 +: 8] = 8'hFF;
        default: v[i*8 +: 8] = 8'($urandom);
      endcase
    end
    return v;
  endfunction

  task automatic drive_rand(output exp_t e);
    logic          sub, cin;
    logic [1:0]    lane, sat;
    logic [DW-1:0] rm, ri;
    sub  = 1'($urandom);
    cin  = 1'($urandom);
    lane = 2'($urandom);
    sat  = 2'($urandom);
    rm   = rnd_operand();
    ri   = rnd_operand();
    set_op(1'b1, sub, lane, sat, cin, rm, ri);
    e = model(rm, ri, sub, lane, sat, cin);
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    inHold = 1'b1;
    set_op(1'b1, 1'b0, 2'b11, 2'b00, 1'b1, '1, '1);
    tick();
    tick();
    n_checks++; if (outValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", outValid); end
    n_checks++; if (outResult !== '0) begin n_fail++; $display("FAIL reset_result got=%h exp=0", outResult); end
    n_checks++; if (outCarry !== 1'b0) begin n_fail++; $display("FAIL reset_carry got=%b exp=0", outCarry); end
    n_checks++; if (outLaneOvf !== '0) begin n_fail++; $display("FAIL reset_ovf got=%h exp=0", outLaneOvf); end
    reset  = 1'b0;
    inHold = 1'b0;
    inValid = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_lane16_wrap();
    set_op(1'b1, 1'b0, 2'b01, 2'b00, 1'b0, 64'h0001_FFFF_7FFF_0001, 64'h0001_0001_0001_FFFF);
    tick();
    inValid = 1'b0;
    n_checks++; if (outValid !== 1'b0) begin n_fail++; $display("FAIL w16_early_valid got=%b exp=0", outValid); end
    tick();
    n_checks++; if (outValid !== 1'b1) begin n_fail++; $display("FAIL w16_valid got=%b exp=1", outValid); end
    n_checks++; if (outResult !== 64'h0002_0000_8000_0000) begin n_fail++; $display("FAIL w16_result got=%h exp=0002000080000000", outResult); end
    n_checks++; if (outLaneOvf !== 8'h0C) begin n_fail++; $display("FAIL w16_ovf got=%h exp=0c", outLaneOvf); end
    n_checks++; if (outCarry !== 1'b0) begin n_fail++; $display("FAIL w16_carry got=%b exp=0", outCarry); end
    tick();
    n_checks++; if (outValid !== 1'b0 || outLaneOvf !== '0) begin n_fail++; $display("FAIL w16_drain got valid=%b ovf=%h exp 0/00", outValid, outLaneOvf); end
  endtask

  task automatic test_lane8_sat();
    set_op(1'b1, 1'b1, 2'b00, 2'b01, 1'b0, {NB{8'h80}}, {NB{8'h01}});
    tick();
    set_op(1'b1, 1'b1, 2'b00, 2'b10, 1'b0, {NB{8'h80}}, {NB{8'h01}});
    tick();
    inValid = 1'b0;
    n_checks++; if (outValid !== 1'b1 || outResult !== {NB{8'h80}}) begin n_fail++; $display("FAIL b8_ssat_result got v=%b %h exp 1 8080808080808080", outValid, outResult); end
    n_checks++; if (outLaneOvf !== 8'hFF) begin n_fail++; $display("FAIL b8_ssat_ovf got=%h exp=ff", outLaneOvf); end
    tick();
    n_checks++; if (outValid !== 1'b1 || outResult !== {NB{8'h7F}}) begin n_fail++; $display("FAIL b8_usat_result got v=%b %h exp 1 7f7f7f7f7f7f7f7f", outValid, outResult); end
    n_checks++; if (outLaneOvf !== 8'h00) begin n_fail++; $display("FAIL b8_usat_ovf got=%h exp=00", outLaneOvf); end
    tick();
  endtask

  task automatic test_adc_sbb();
    set_op(1'b1, 1'b0, 2'b11, 2'b00, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0);
    tick();
    set_op(1'b1, 1'b1, 2'b11, 2'b00, 1'b0, 64'h0, 64'h0);
    tick();
    inValid = 1'b0;
    n_checks++; if (outResult !== 64'h0 || outCarry !== 1'b1) begin n_fail++; $display("FAIL adc got res=%h c=%b exp 0/1", outResult, outCarry); end
    n_checks++; if (outLaneOvf !== 8'h00) begin n_fail++; $display("FAIL adc_ovf got=%h exp=00", outLaneOvf); end
    tick();
    n_checks++; if (outResult !== 64'hFFFF_FFFF_FFFF_FFFF || outCarry !== 1'b0) begin n_fail++; $display("FAIL sbb got res=%h c=%b exp ffffffffffffffff/0", outResult, outCarry); end
    // Reserved sat mode must follow the wrap path, carry-in included.
    set_op(1'b1, 1'b0, 2'b11, 2'b11, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0);
    tick();
    inValid = 1'b0;
    tick();
    n_checks++; if (outResult !== 64'h8000_0000_0000_0000 || outCarry !== 1'b0 || outLaneOvf !== 8'hFF) begin
      n_fail++; $display("FAIL rsvd_sat got res=%h c=%b ovf=%h exp 8000000000000000/0/ff", outResult, outCarry, outLaneOvf);
    end
  endtask

  task automatic test_lane32_usat();
    set_op(1'b1, 1'b0, 2'b10, 2'b10, 1'b1, 64'hFFFF_FFF0_0000_0010, 64'h0000_0020_0000_0020);
    tick();
    inValid = 1'b0;
    tick();
    n_checks++; if (outResult !== 64'hFFFF_FFFF_0000_0030) begin n_fail++; $display("FAIL l32_usat_result got=%h exp=ffffffff00000030", outResult); end
    n_checks++; if (outLaneOvf !== 8'hF0 || outCarry !== 1'b0) begin n_fail++; $display("FAIL l32_usat_flags got ovf=%h c=%b exp f0/0", outLaneOvf, outCarry); end
  endtask

  task automatic test_back_to_back();
    exp_t ep, ea, eb, ec, ex;
    inHold = 1'b0;
    drive_rand(ep);
    tick();
    drive_rand(ea);
    tick();
    n_checks++; if (outValid !== 1'b1 || {outResult, outCarry, outLaneOvf} !== ep) begin n_fail++; $display("FAIL b2b_p got %h/%b/%h exp %h", outResult, outCarry, outLaneOvf, ep); end
    drive_rand(ex);
    inHold = 1'b1;
    tick();
    n_checks++; if (outValid !== 1'b1 || {outResult, outCarry, outLaneOvf} !== ep) begin n_fail++; $display("FAIL b2b_hold1 got %h/%b/%h exp %h", outResult, outCarry, outLaneOvf, ep); end
    drive_rand(ex);
    tick();
    n_checks++; if (outValid !== 1'b1 || {outResult, outCarry, outLaneOvf} !== ep) begin n_fail++; $display("FAIL b2b_hold2 got %h/%b/%h exp %h", outResult, outCarry, outLaneOvf, ep); end
    inHold = 1'b0;
    drive_rand(eb);
    tick();
    n_checks++; if (outValid !== 1'b1 || {outResult, outCarry, outLaneOvf} !== ea) begin n_fail++; $display("FAIL b2b_a got %h/%b/%h exp %h", outResult, outCarry, outLaneOvf, ea); end
    drive_rand(ec);
    tick();
    n_checks++; if (outValid !== 1'b1 || {outResult, outCarry, outLaneOvf} !== eb) begin n_fail++; $display("FAIL b2b_b got %h/%b/%h exp %h", outResult, outCarry, outLaneOvf, eb); end
    inValid = 1'b0;
    tick();
    n_checks++; if (outValid !== 1'b1 || {outResult, outCarry, outLaneOvf} !== ec) begin n_fail++; $display("FAIL b2b_c got %h/%b/%h exp %h", outResult, outCarry, outLaneOvf, ec); end
    tick();
    n_checks++; if (outValid !== 1'b0 || outLaneOvf !== '0) begin n_fail++; $display("FAIL b2b_drain got valid=%b ovf=%h exp 0/00", outValid, outLaneOvf); end
  endtask

  task automatic test_reset_inflight();
    exp_t e1, e4;
    drive_rand(e1);
    tick();
    drive_rand(e1);
    tick();
    reset = 1'b1;
    drive_rand(e1);
    tick();
    n_checks++; if (outValid !== 1'b0 || outResult !== '0 || outCarry !== 1'b0 || outLaneOvf !== '0) begin
      n_fail++; $display("FAIL rst_flight got v=%b res=%h c=%b ovf=%h exp all 0", outValid, outResult, outCarry, outLaneOvf);
    end
    reset = 1'b0;
    drive_rand(e4);
    tick();
    inValid = 1'b0;
    n_checks++; if (outValid !== 1'b0) begin n_fail++; $display("FAIL rst_flushed got valid=%b exp=0", outValid); end
    tick();
    n_checks++; if (outValid !== 1'b1 || {outResult, outCarry, outLaneOvf} !== e4) begin n_fail++; $display("FAIL rst_after got v=%b %h/%b/%h exp %h", outValid, outResult, outCarry, outLaneOvf, e4); end
    tick();
  endtask

  task automatic test_random();
    ent_t q[$];
    ent_t ent;
    exp_t e;
    logic v, h;
    logic [DW-1:0] p_res;
    logic p_vld, p_c;
    logic [NB-1:0] p_ovf;
    p_vld = outValid; p_res = outResult; p_c = outCarry; p_ovf = outLaneOvf;
    for (int cyc = 0; cyc < 600; cyc++) begin
      drive_rand(e);
      v = ($urandom_range(0, 3) != 0);
      h = ($urandom_range(0, 4) == 0);
      inValid = v;
      inHold  = h;
      tick();
      if (h) begin
        n_checks++; if (outValid !== p_vld || outResult !== p_res || outCarry !== p_c || outLaneOvf !== p_ovf) begin
          n_fail++; $display("FAIL rnd_hold cyc=%0d got %b/%h/%b/%h exp %b/%h/%b/%h", cyc, outValid, outResult, outCarry, outLaneOvf, p_vld, p_res, p_c, p_ovf);
        end
      end else begin
        foreach (q[i]) q[i].age--;
        if (q.size() > 0 && q[0].age == 0) begin
          ent = q.pop_front();
          n_checks++; if (outValid !== 1'b1 || {outResult, outCarry, outLaneOvf} !== ent.e) begin
            n_fail++; $display("FAIL rnd_op cyc=%0d got v=%b %h/%b/%h exp %h", cyc, outValid, outResult, outCarry, outLaneOvf, ent.e);
          end
        end else begin
          n_checks++; if (outValid !== 1'b0 || outLaneOvf !== '0) begin
            n_fail++; $display("FAIL rnd_idle cyc=%0d got valid=%b ovf=%h exp 0/00", cyc, outValid, outLaneOvf);
          end
        end
        if (v) begin
          ent.e   = e;
          ent.age = 1;
          q.push_back(ent);
        end
      end
      p_vld = outValid; p_res = outResult; p_c = outCarry; p_ovf = outLaneOvf;
    end
    inValid = 1'b0;
    inHold  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      foreach (q[i]) q[i].age--;
      if (q.size() > 0 && q[0].age == 0) begin
        ent = q.pop_front();
        n_checks++; if (outValid !== 1'b1 || {outResult, outCarry, outLaneOvf} !== ent.e) begin
          n_fail++; $display("FAIL rnd_drain got v=%b %h/%b/%h exp %h", outValid, outResult, outCarry, outLaneOvf, ent.e);
        end
      end
    end
    n_checks++; if (q.size() != 0) begin n_fail++; $display("FAIL rnd_leftover got=%0d exp=0", q.size()); end
  endtask

  initial begin
    reset    = 1'b1;
    inHold   = 1'b0;
    set_op(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, '0, '0);
    test_reset();
    test_lane16_wrap();
    test_lane8_sat();
    test_adc_sbb();
    test_lane32_usat();
    test_back_to_back();
    test_reset_inflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jx2_ex_padd_pipe.md
Name: jx2_ex_padd_pipe

Overview:
- Pipelined packed add/subtract unit for the EX stage: a successor to the single-cycle fixed 16/32-bit carry-select adder.
- Generalised to a parametrised datapath width. Lane size (8/16/32/64) is selected at runtime.
- Adds wrapping, signed-saturating and unsigned-saturating modes, a full-width carry chain with carry-in/out, and a two-stage pipeline with valid/hold.
- Sits between operand fetch (Rm, Ri) and writeback; consumed by PADD.x / PSUB.x / ADC / SBB.

Parameters:
- DATA_WIDTH, 64, datapath width in bits; must be 64 or 128.
- SEG_WIDTH, 8, carry-select segment width; fixed at 8 so byte lanes work; other values are illegal.

Ports:
- clock  in  1  core clock
- reset  in  1  synchronous, active-high reset
- inValid  in  1  operands/op valid this cycle
- inHold  in  1  pipeline stall; freezes both stages
- inSub  in  1  0=add (Rm+Ri), 1=subtract (Rm-Ri)
- inLane  in  2  00=8b, 01=16b, 10=32b, 11=64b lanes
- inSat  in  2  00=wrap, 01=signed sat, 10=unsigned sat, 11=reserved (treated as wrap)
- inCarry  in  1  carry-in (add) / inverted borrow-in (sub); used only when inLane=11 and inSat=00
- regValRm  in  DATA_WIDTH  first operand
- regValRi  in  DATA_WIDTH  second operand
- outValid  out  1  result valid
- outResult  out  DATA_WIDTH  packed result
- outCarry  out  1  carry-out of lane 0 (the lowest 64-bit lane) when inLane=11; 0 otherwise
- outLaneOvf  out  DATA_WIDTH/8  per-byte flag; set on every byte of a lane whose result saturated (sat modes) or overflowed (wrap mode, signed sense)

Behaviour:
- Reset: outValid=0, outResult=0, outCarry=0, outLaneOvf=0; all pipeline registers cleared. Reset overrides inHold.
- Latency: 2 cycles. An op accepted at edge N (inValid=1, inHold=0) appears at edge N+2.
- inHold=1: no register changes; outputs hold their values; an inValid arriving during hold is ignored (the issuer must hold the operand).
- Stage 1 (registered):
  - Per 8-bit segment s, compute sum0 and sum1 (9-bit, carry-in 0 and 1) of Rm_s + (inSub ? ~Ri_s : Ri_s).
  - Latch the op controls, plus each segment's operand sign bits for saturation.
- Stage 2 (registered):
  - Resolve carries segment by segment.
  - The carry into segment 0 of each lane is: inSub ? 1 : 0, except lane size 64 in wrap mode, where it is inCarry (add) or inCarry (sub; inCarry=1 means no borrow).
  - Carry into any other segment is the ripple of the previous segment's selected carry; it is cut at lane boundaries.
- Signed overflow per lane: operand signs equal (after inversion for sub) and result sign differs.
- Saturation:
  - Signed sat: replace with 0x7F.. if positive overflow, 0x80.. if negative overflow.
  - Unsigned sat: on add carry-out, result = all ones; on sub borrow (carry-out=0), result = 0.
- outCarry is the carry out of bit 63 when inLane=11 and inSat=00; otherwise 0.
- outValid(N+2) = inValid accepted at N. While outValid=0, outResult still updates (don't-care) but outLaneOvf is forced to 0.
- Back-to-back ops: full throughput of 1/cycle when inHold=0.
- Reserved inSat=11 behaves exactly as 00, with no error signal.

Decomposition:
- Shared package jx2_alu_pkg:
  - lane-size encodings (LANE_B, LANE_W, LANE_L, LANE_Q);
  - saturation encodings (SAT_NONE, SAT_S, SAT_U);
  - SEG_WIDTH constant;
  - function lane_first_seg(lane, seg) returning whether segment starts a lane.
- One sub-module, jx2_alu_seg8, computes {sum0, sum1} for one 8-bit segment. It is instantiated DATA_WIDTH/8 times in stage 1.

Test Plan:
- Lane 01 wrap add, Rm=0x0001_FFFF_7FFF_0001, Ri=0x0001_0001_0001_FFFF -> result 0x0002_0000_8000_0000 at +2 cycles; outLaneOvf bytes 2-3 set (0x7FFF+1 overflow), others 0.
- Lane 00 signed-sat sub, Rm bytes 0x80 each, Ri bytes 0x01 each -> every byte 0x80, outLaneOvf all ones; same operands with inSat=10 -> 0x7F each, no flags.
- Lane 11 wrap ADC, Rm=0xFFFF_FFFF_FFFF_FFFF, Ri=0, inCarry=1 -> result 0, outCarry=1; SBB with Rm=0, Ri=0, inCarry=0 -> result all ones, outCarry=0.
- Lane 10 unsigned-sat add, Rm=0xFFFF_FFF0_0000_0010, Ri=0x0000_0020_0000_0020 -> 0xFFFF_FFFF_0000_0030; flags set on bytes 4-7 only.
- Issue 3 ops back-to-back, assert inHold on the 2nd cycle for 2 cycles -> results emerge in order, none lost or duplicated; outputs frozen during hold.
- Assert reset with ops in flight -> next cycle outValid=0, outResult=0; an op issued the cycle after reset deasserts completes normally at +2.
